// File: rtl/exe_stage_mc.sv
// exe_stage_mc: EXE stage with iterative divider, ready_go stall and sub-word store enables; EXE_ALE_EN adds misalignment exception.
module alu #(
  parameter int XLEN = 32
) (
  input  logic [11:0]     alu_op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic [XLEN-1:0] alu_result_o
);
  localparam int SW = $clog2(XLEN);
  logic            sub;
  logic [XLEN:0]   sum;
  logic            slt;
  logic            sltu;
  logic [SW-1:0]   sh;
  assign sub  = alu_op_i[1] | alu_op_i[2] | alu_op_i[3];
  assign sum  = {1'b0, src1_i} + {1'b0, src2_i ^ {XLEN{sub}}} + {{XLEN{1'b0}}, sub};
  assign slt  = (src1_i[XLEN-1] & ~src2_i[XLEN-1]) | (~(src1_i[XLEN-1] ^ src2_i[XLEN-1]) & sum[XLEN-1]);
  assign sltu = ~sum[XLEN];
  assign sh   = src2_i[SW-1:0];
  assign alu_result_o = ({XLEN{alu_op_i[0] | alu_op_i[1]}} & sum[XLEN-1:0])
                      | ({XLEN{alu_op_i[2]}}  & XLEN'(slt))
                      | ({XLEN{alu_op_i[3]}}  & XLEN'(sltu))
                      | ({XLEN{alu_op_i[4]}}  & (src1_i & src2_i))
                      | ({XLEN{alu_op_i[5]}}  & ~(src1_i | src2_i))
                      | ({XLEN{alu_op_i[6]}}  & (src1_i | src2_i))
                      | ({XLEN{alu_op_i[7]}}  & (src1_i ^ src2_i))
                      | ({XLEN{alu_op_i[8]}}  & (src1_i << sh))
                      | ({XLEN{alu_op_i[9]}}  & (src1_i >> sh))
                      | ({XLEN{alu_op_i[10]}} & $unsigned($signed(src1_i) >>> sh))
                      | ({XLEN{alu_op_i[11]}} & src2_i);
endmodule

module exe_stage_mc #(
  parameter int XLEN     = 32,
  parameter int DEST_W   = 5,
  parameter int ID_BUS_W = 4*XLEN+22+DEST_W,
`ifdef EXE_ALE_EN
  parameter int MEM_BUS_W = 2*XLEN+7+DEST_W
`else
  parameter int MEM_BUS_W = 2*XLEN+6+DEST_W
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ID_BUS_W-1:0]  id_to_exe_bus,
  input  logic                 id_to_exe_valid,
  output logic                 exe_allow_in,
  input  logic                 mem_allow_in,
  output logic                 exe_to_mem_valid,
  output logic [MEM_BUS_W-1:0] exe_to_mem_bus,
  output logic                 data_sram_en,
  output logic [3:0]           data_sram_we,
  output logic [XLEN-1:0]      data_sram_addr,
  output logic [XLEN-1:0]      data_sram_wdata
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  logic [ID_BUS_W-1:0] bus_q;
  logic                valid_q;
  logic [XLEN-1:0]     pc, rj, imm, rkd;
  logic [11:0]         alu_op;
  logic                div_en, div_mod, div_signed;
  logic [1:0]          mem_size;
  logic                src1_is_pc, src2_is_imm, mem_we, res_from_mem, gr_we;
  logic [DEST_W-1:0]   dest;
  logic [XLEN-1:0]     alu_result;
  logic                ready_go;
  div_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     rem_q, quo_q, dsr_q;
  logic                qneg_q, rneg_q;
  logic                start, a_neg;
  logic [XLEN:0]       trial, diff;
  logic [XLEN-1:0]     div_res, result, addr, wdata;
  logic [3:0]          mask;
  logic                mem_req, ale;
  assign {pc, rj, imm, rkd, alu_op, div_en, div_mod, div_signed, mem_size,
          src1_is_pc, src2_is_imm, mem_we, res_from_mem, gr_we, dest} = bus_q;
  alu #(.XLEN(XLEN)) u_alu (
    .alu_op_i    (alu_op),
    .src1_i      (src1_is_pc ? pc : rj),
    .src2_i      (src2_is_imm ? imm : rkd),
    .alu_result_o(alu_result)
  );
  assign exe_allow_in     = !valid_q | (ready_go & mem_allow_in);
  assign exe_to_mem_valid = valid_q & ready_go;
  // Pipeline valid bit: refilled from ID whenever EXE can accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else if (exe_allow_in) valid_q <= id_to_exe_valid;
  end
  // Instruction payload, only overwritten by a real incoming instruction
  always_ff @(posedge clk) begin
    if (id_to_exe_valid & exe_allow_in) bus_q <= id_to_exe_bus;
  end
  // Divider state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Divider next state: start on a valid div, finish after XLEN steps, release on handoff
  always_comb begin
    state_d = (state_q == IDLE && valid_q && div_en)               ? BUSY :
              (state_q == BUSY && cnt_q == CW'(XLEN-1))            ? DONE :
              (state_q == DONE && valid_q && mem_allow_in)         ? IDLE : state_q;
  end
  // Stage completion: non-div ops finish at once, divs only once the divider is DONE
  always_comb begin
    ready_go = !div_en | (state_q == DONE);
  end
  assign start = state_q == IDLE && valid_q && div_en;
  assign a_neg = div_signed & rj[XLEN-1];
  assign trial = {rem_q, quo_q[XLEN-1]};
  assign diff  = trial - {1'b0, dsr_q};
  // Step counter, cleared on each new division
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (start) cnt_q <= '0;
    else if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
  end
  // Restoring division on magnitudes; a zero divisor yields all-ones quotient and the dividend as remainder
  always_ff @(posedge clk) begin
    if (start) begin
      rem_q  <= '0;
      quo_q  <= a_neg ? -rj : rj;
      dsr_q  <= (div_signed & rkd[XLEN-1]) ? -rkd : rkd;
      qneg_q <= div_signed & (rj[XLEN-1] ^ rkd[XLEN-1]) & (|rkd);
      rneg_q <= a_neg;
    end else if (state_q == BUSY) begin
      rem_q <= diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
    end
  end
  assign div_res = div_mod ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);
  assign result  = div_en ? div_res : alu_result;
  assign mem_req = mem_we | res_from_mem;
`ifdef EXE_ALE_EN
  assign ale  = mem_req & ((mem_size == 2'd1 && alu_result[0]) || (mem_size == 2'd2 && |alu_result[1:0]));
  assign addr = alu_result;
`else
  assign ale  = 1'b0;
  assign addr = mem_size == 2'd2 ? {alu_result[XLEN-1:2], 2'b00} :
                mem_size == 2'd1 ? {alu_result[XLEN-1:1], 1'b0} : alu_result;
`endif
  // Byte lanes and lane-replicated store data per access size
  always_comb begin
    mask  = mem_size == 2'd0 ? 4'b0001 << addr[1:0] :
            mem_size == 2'd1 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wdata = mem_size == 2'd0 ? {4{rkd[7:0]}} :
            mem_size == 2'd1 ? {2{rkd[15:0]}} : rkd;
  end
  assign data_sram_en    = exe_to_mem_valid & mem_allow_in & mem_req & !ale;
  assign data_sram_we    = (mem_we & data_sram_en) ? mask : 4'b0000;
  assign data_sram_addr  = valid_q ? addr : '0;
  assign data_sram_wdata = valid_q ? wdata : '0;
`ifdef EXE_ALE_EN
  assign exe_to_mem_bus = valid_q ? {ale, result, res_from_mem, gr_we, dest, pc, mem_size, alu_result[1:0]} : '0;
`else
  assign exe_to_mem_bus = valid_q ? {result, res_from_mem, gr_we, dest, pc, mem_size, alu_result[1:0]} : '0;
`endif
endmodule
